imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the instruction memory that the core fetches from. Receives a framed
//  byte stream (valid/ready), assembles big-endian 32-bit words and writes them into sequential
//  instruction-memory addresses. Holds the core stalled (cpu_hold) until a frame loads and its
//  checksum passes. Frame: LEN_HI, LEN_LO (word count N), N x 4 data bytes (MSB first), CKS.
// PARAMETERS
//  ADDR_W     18   instruction address width, matches the PC width
//  BASE_ADDR  0    instruction address of the first loaded word
//  MAX_WORDS  256  largest legal N; a larger N is a frame error
// PORTS
//  clk        in   1       single clock, all logic on the rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle pulse; starts a load; ignored while busy=1
//  rx_data    in   8       stream byte
//  rx_valid   in   1       rx_data is valid
//  rx_ready   out  1       loader accepts a byte; a transfer is rx_valid&rx_ready at the edge
//  imem_addr  out  ADDR_W  instruction-memory write address
//  imem_data  out  32      instruction-memory write word
//  imem_wren  out  1       1-cycle write strobe
//  cpu_hold   out  1       1 = core held (stall/reset); 0 only after a successful load
//  busy       out  1       a frame is in progress
//  done       out  1       sticky: last frame loaded and checksum matched
//  error      out  1       sticky: last frame bad (length or checksum)
// BEHAVIOUR
//  Reset values: state IDLE; rx_ready=0, imem_wren=0, imem_addr=BASE_ADDR, imem_data=0,
//   cpu_hold=1, busy=0, done=0, error=0. Internal word counter, byte counter and checksum are 0.
//  FSM: IDLE -> LEN_HI -> LEN_LO -> {DATA | CHECK | ERROR}; DATA -> WRITE -> {DATA | CHECK};
//   CHECK -> {DONE | ERROR}. DONE and ERROR are held until start (-> LEN_HI) or rst.
//  IDLE/DONE/ERROR: rx_ready=0, busy=0. start: clear done, error, checksum, counters;
//   cpu_hold=1; next cycle enter LEN_HI with busy=1.
//  rx_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in every other state. No byte is lost
//   or duplicated under any rx_valid pattern.
//  Checksum: running XOR of every accepted byte from LEN_HI up to the last data byte.
//  LEN_LO accept: N={LEN_HI,LEN_LO}. N=0 -> CHECK. N>MAX_WORDS -> ERROR with no writes.
//   Otherwise -> DATA.
//  DATA: shift each byte into a word register MSB first. The 4th byte goes to WRITE.
//  WRITE (exactly 1 cycle): imem_wren=1, imem_data=word, imem_addr=BASE_ADDR+index,
//   wrapping mod 2^ADDR_W. Then index+1. If index+1==N -> CHECK, else -> DATA.
//   Latency: the write strobe is asserted in the cycle after the 4th byte is accepted.
//  CHECK accept: byte==checksum -> DONE (done=1, cpu_hold=0 from the next cycle).
//   Otherwise -> ERROR (error=1, cpu_hold stays 1). Words already written are not undone.
//  start in DONE: re-asserts cpu_hold=1 in the next cycle and reloads.
//  rst mid-frame: returns to the reset values in the next cycle. A write in that cycle is
//   suppressed, because rst has priority over every other input.
//  imem_addr/imem_data keep their last values while imem_wren=0.
// TESTING
//  1 rst, start, bytes 00 02 12 34 56 78 9A BC DE F0 02 -> writes [0]=0x12345678,
//    [1]=0x9ABCDEF0, one wren cycle each; done=1, error=0, cpu_hold=0.
//  2 same frame with last byte 03 -> both writes occur; error=1, done=0, cpu_hold=1.
//  3 bytes 00 00 00 -> no wren; done=1, cpu_hold=0. With 00 00 01 -> error=1.
//  4 MAX_WORDS=256, bytes 01 01 -> ERROR right after the 2nd byte, rx_ready=0, no wren.
//  5 random rx_valid gaps plus a 4-word frame with BASE_ADDR=0x3FFFE -> addresses
//    3FFFE, 3FFFF, 00000, 00001; rx_ready=0 in each WRITE cycle; data intact.
//  6 rst after 5 accepted bytes -> all reset values next cycle; a new start loads
//    frame 1 correctly. start pulsed while busy -> ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
//==============================================================================
// Module   : imem_loader_if
// Purpose  : Groups the boot byte stream (valid/ready) and the instruction-
//            memory write port used by imem_loader.
// Signals  : rx_data   8       stream byte
//            rx_valid  1       rx_data is valid
//            rx_ready  1       loader accepts a byte this edge
//            imem_addr ADDR_W  instruction-memory write address
//            imem_data 32      instruction-memory write word
//            imem_wren 1       one-cycle write strobe
// Modports : slave  - the loader (consumes the stream, drives the write port)
//            master - the environment (sources the stream, observes writes)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 18
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              imem_wren;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_addr,
    output imem_data,
    output imem_wren
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_addr,
    input  imem_data,
    input  imem_wren
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
//==============================================================================
// Module   : imem_loader
// Purpose  : Boot-time instruction-memory writer. Accepts a framed byte stream
//            (LEN_HI, LEN_LO, N x 4 data bytes MSB first, CKS), writes each
//            assembled big-endian word to sequential addresses starting at
//            BASE_ADDR and keeps the core stalled until a frame loads with a
//            matching XOR checksum.
// Ports    : clk       in   single clock, rising edge
//            rst       in   synchronous active-high reset
//            start     in   one-cycle pulse, starts a load when not busy
//            bus       slave modport: rx_* stream in, imem_* write port out
//            cpu_hold  out  1 = core held; 0 only after a good load
//            busy      out  a frame is in progress
//            done      out  sticky: last frame loaded, checksum matched
//            error     out  sticky: last frame bad (length or checksum)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_loader #(
  parameter int                ADDR_W    = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // 17 bits so that any 16-bit length can be compared without overflow.
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t            state_q,     state_d;
  logic [15:0]       len_q,       len_d;
  logic [15:0]       idx_q,       idx_d;
  logic [1:0]        bcnt_q,      bcnt_d;
  logic [7:0]        cks_q,       cks_d;
  logic [23:0]       word_q,      word_d;
  logic              rx_ready_q,  rx_ready_d;
  logic              wren_q,      wren_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [31:0]       data_q,      data_d;
  logic              cpu_hold_q,  cpu_hold_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;

  logic              accept;
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] idx_addr;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    cks_d      = cks_q;
    word_d     = word_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    // rx_ready is a registered function of the state, so it is already
    // valid for the current edge and the transfer qualifier is exact.
    accept   = rx_ready_q & bus.rx_valid;
    n_words  = {len_q[15:8], bus.rx_data};
    // Truncating the index to ADDR_W makes BASE_ADDR+index wrap naturally.
    idx_addr = ADDR_W'(idx_q);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cks_d      = 8'h00;
          idx_d      = 16'h0000;
          bcnt_d     = 2'd0;
          cpu_hold_d = 1'b1;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d   = {bus.rx_data, 8'h00};
          cks_d   = cks_q ^ bus.rx_data;
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = n_words;
          cks_d = cks_q ^ bus.rx_data;
          if (n_words == 16'h0000) begin
            state_d = S_CHECK;
          end else if ({1'b0, n_words} > MAX_N) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d = {word_q[15:0], bus.rx_data};
          cks_d  = cks_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Write port is loaded on entry so it is valid in WRITE.
            state_d = S_WRITE;
            data_d  = {word_q, bus.rx_data};
            addr_d  = BASE_ADDR + idx_addr;
          end
        end
      end

      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if ((idx_q + 16'd1) == len_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end

      S_CHECK: begin
        if (accept) begin
          if (bus.rx_data == cks_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs derived from the next state so they are registered with it.
    rx_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CHECK);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                   (state_d == S_ERROR));
    wren_d     = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'h0000;
      idx_q      <= 16'h0000;
      bcnt_q     <= 2'd0;
      cks_q      <= 8'h00;
      word_q     <= 24'h000000;
      rx_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= BASE_ADDR;
      data_q     <= 32'h00000000;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      cks_q      <= cks_d;
      word_q     <= word_d;
      rx_ready_q <= rx_ready_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.imem_wren = wren_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_data = data_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//==============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Expected writes are queued
//            as the 4th byte of each word is driven and popped when the write
//            strobe appears; status flags are checked after each frame.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int          ADDR_W = 18;
  localparam logic [17:0] BASE   = 18'h3FFFE;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, busy, done, error;

  int total    = 0;
  int bad      = 0;
  int wr_count = 0;
  int start_at = -1;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .MAX_WORDS(256)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge and score any write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.imem_wren === 1'b1) begin
      wr_count++;
      check("ready_low_in_write", bus.rx_ready, 1'b0);
      check("write_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", bus.imem_addr, e.addr);
        check("wr_data", bus.imem_data, e.data);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte until accepted (bounded); optional random idle gap first.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    bit acc;
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        tick();
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = bus.rx_ready;
      if (with_start && i == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    bus.rx_valid = 1'b0;
    check("byte_accepted", acc, 1'b1);
  endtask

  // Send a frame of frame_words; checksum byte is XORed with cks_flip.
  task automatic send_frame(input logic [15:0] n, input logic [7:0] cks_flip, input bit gaps);
    logic [7:0] cks;
    logic [7:0] b;
    int         k;
    k   = 0;
    cks = n[15:8] ^ n[7:0];
    send_byte(n[15:8], gaps, start_at == k); k++;
    send_byte(n[7:0],  gaps, start_at == k); k++;
    for (int w = 0; w < int'(n); w++) begin
      for (int j = 3; j >= 0; j--) begin
        b   = frame_words[w][j*8 +: 8];
        cks = cks ^ b;
        if (j == 0) exp_q.push_back('{addr: 18'(BASE + 18'(w)), data: frame_words[w]});
        send_byte(b, gaps, start_at == k); k++;
        if (j == 0) check("write_latency", bus.imem_wren, 1'b1);
      end
    end
    send_byte(cks ^ cks_flip, gaps, start_at == k);
  endtask

  task automatic check_reset(input string p);
    check({p, "_rx_ready"}, bus.rx_ready,  1'b0);
    check({p, "_wren"},     bus.imem_wren, 1'b0);
    check({p, "_addr"},     bus.imem_addr, BASE);
    check({p, "_data"},     bus.imem_data, 32'h0);
    check({p, "_cpu_hold"}, cpu_hold,      1'b1);
    check({p, "_busy"},     busy,          1'b0);
    check({p, "_done"},     done,          1'b0);
    check({p, "_error"},    error,         1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    // Two-word frame with good checksum (0x02).
    pulse_start();
    check("t1_busy",     busy,         1'b1);
    check("t1_hold",     cpu_hold,     1'b1);
    check("t1_rx_ready", bus.rx_ready, 1'b1);
    frame_words = '{32'h12345678, 32'h9ABCDEF0};
    wr_count = 0;
    send_frame(16'd2, 8'h00, 1'b0);
    check("t1_done",   done,          1'b1);
    check("t1_error",  error,         1'b0);
    check("t1_hold",   cpu_hold,      1'b0);
    check("t1_busy",   busy,          1'b0);
    check("t1_writes", wr_count,      2);
    check("t1_q",      exp_q.size(),  0);

    // Same frame, checksum byte 0x03: writes happen, frame flagged bad.
    pulse_start();
    check("t2_rehold", cpu_hold, 1'b1);
    check("t2_clr",    done,     1'b0);
    wr_count = 0;
    send_frame(16'd2, 8'h01, 1'b0);
    check("t2_error",  error,    1'b1);
    check("t2_done",   done,     1'b0);
    check("t2_hold",   cpu_hold, 1'b1);
    check("t2_writes", wr_count, 2);

    // Empty frame: good then bad checksum.
    frame_words = {};
    wr_count = 0;
    pulse_start();
    check("t3_err_clr", error, 1'b0);
    send_frame(16'd0, 8'h00, 1'b0);
    check("t3_done",   done,     1'b1);
    check("t3_hold",   cpu_hold, 1'b0);
    pulse_start();
    send_frame(16'd0, 8'h01, 1'b0);
    check("t3_error",  error,    1'b1);
    check("t3_done2",  done,     1'b0);
    check("t3_writes", wr_count, 0);

    // Length 257 exceeds MAX_WORDS: error straight after LEN_LO.
    pulse_start();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    check("t4_error",    error,        1'b1);
    check("t4_rx_ready", bus.rx_ready, 1'b0);
    check("t4_busy",     busy,         1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (4) tick();
    bus.rx_valid = 1'b0;
    check("t4_still_ready_low", bus.rx_ready, 1'b0);
    check("t4_writes",          wr_count,     0);

    // Four random words with idle gaps; addresses wrap past 0x3FFFF.
    frame_words = {};
    for (int i = 0; i < 4; i++) frame_words.push_back($urandom);
    wr_count = 0;
    pulse_start();
    send_frame(16'd4, 8'h00, 1'b1);
    check("t5_done",   done,         1'b1);
    check("t5_writes", wr_count,     4);
    check("t5_q",      exp_q.size(), 0);

    // Reset after five accepted bytes, then a clean reload with a stray start.
    pulse_start();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_reset("t6_rst");
    rst = 1'b0;
    tick();
    frame_words = '{32'h12345678, 32'h9ABCDEF0};
    wr_count = 0;
    start_at = 4;
    pulse_start();
    send_frame(16'd2, 8'h00, 1'b0);
    start_at = -1;
    check("t6_done",   done,         1'b1);
    check("t6_error",  error,        1'b0);
    check("t6_hold",   cpu_hold,     1'b0);
    check("t6_writes", wr_count,     2);
    check("t6_q",      exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
